// File: rtl/operand_select_buf.sv
`default_nettype none
// ============================================================================
//  Module   : operand_select_buf
//  Purpose  : Second-stage operand selector for the modular add/sub datapath.
//             Picks one of NSETS candidate (a, b) operand pairs per
//             transaction, optionally swaps the pair, and passes the result
//             downstream through a 2-entry valid/ready buffer. Outputs are
//             registered and one transaction per cycle can be sustained.
//
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             in_valid/in_ready - upstream handshake
//             sel, swap         - set index and operand-exchange request
//             a_in, b_in        - packed candidate operands, set k at
//                                 [k*WIDTH +: WIDTH]
//             out_valid/out_ready - downstream handshake
//             a, b              - selected operands (head entry)
//             sel_err           - head entry was pushed with sel >= NSETS
//             par               - stored parity of the head entry {a, b}
//
//  Config   : OPSEL_PARITY_EN   - when defined, parity of {a, b} is computed
//                                 at push and stored per entry; otherwise the
//                                 parity logic is removed and par is tied 0.
//
//  Revision : 1.0 - initial release
// ============================================================================
module operand_select_buf #(
    parameter int WIDTH = 4,
    parameter int NSETS = 2,
    parameter int SEL_W = (NSETS > 1) ? $clog2(NSETS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     swap,
    input  logic [NSETS*WIDTH-1:0]   a_in,
    input  logic [NSETS*WIDTH-1:0]   b_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         a,
    output logic [WIDTH-1:0]         b,
    output logic                     sel_err,
    output logic                     par
);

    // Buffer occupancy encoding
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_push;
    logic             w_pop;

    logic             w_in_range;
    logic [SEL_W-1:0] w_idx;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [WIDTH-1:0] w_new_a;
    logic [WIDTH-1:0] w_new_b;
    logic             w_new_err;

    // Two storage slots: head is what the outputs present, tail holds the
    // second entry only while the buffer is FULL.
    logic [WIDTH-1:0] r_head_a;
    logic [WIDTH-1:0] r_head_b;
    logic             r_head_err;
    logic [WIDTH-1:0] r_tail_a;
    logic [WIDTH-1:0] r_tail_b;
    logic             r_tail_err;

    logic             w_load_head_new;
    logic             w_load_tail;
    logic             w_shift;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign in_ready  = !rst && (r_state != c_ST_FULL);
    assign out_valid = (r_state != c_ST_EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Set selection. When NSETS fills the whole index space every sel
    // value is legal, so the range check collapses to a constant.
    // ------------------------------------------------------------------
    if ((1 << SEL_W) > NSETS) begin : g_range_chk
        assign w_in_range = (sel < SEL_W'(NSETS));
    end else begin : g_range_full
        assign w_in_range = 1'b1;
    end

    assign w_idx     = w_in_range ? sel : '0;
    assign w_new_err = !w_in_range;

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = 0; k < NSETS; k++) begin
            if (w_idx == SEL_W'(k)) begin
                w_sel_a = a_in[k*WIDTH +: WIDTH];
                w_sel_b = b_in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_new_a = swap ? w_sel_b : w_sel_a;
    assign w_new_b = swap ? w_sel_a : w_sel_b;

    // ------------------------------------------------------------------
    // Occupancy state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_EMPTY: if (w_push) w_state_nxt = c_ST_ONE;
            c_ST_ONE: begin
                if (w_push && !w_pop)      w_state_nxt = c_ST_FULL;
                else if (!w_push && w_pop) w_state_nxt = c_ST_EMPTY;
            end
            c_ST_FULL:  if (w_pop) w_state_nxt = c_ST_ONE;
            default:    w_state_nxt = c_ST_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // Data path. A push into ONE with a simultaneous pop replaces the head
    // directly; without a pop it lands in the tail. Popping FULL promotes
    // the tail. No push is possible while FULL.
    // ------------------------------------------------------------------
    assign w_load_head_new = w_push &&
                             ((r_state == c_ST_EMPTY) || ((r_state == c_ST_ONE) && w_pop));
    assign w_load_tail     = w_push && (r_state == c_ST_ONE) && !w_pop;
    assign w_shift         = w_pop && (r_state == c_ST_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_a   <= '0;
            r_head_b   <= '0;
            r_head_err <= 1'b0;
            r_tail_a   <= '0;
            r_tail_b   <= '0;
            r_tail_err <= 1'b0;
        end else begin
            if (w_load_head_new) begin
                r_head_a   <= w_new_a;
                r_head_b   <= w_new_b;
                r_head_err <= w_new_err;
            end else if (w_shift) begin
                r_head_a   <= r_tail_a;
                r_head_b   <= r_tail_b;
                r_head_err <= r_tail_err;
            end
            if (w_load_tail) begin
                r_tail_a   <= w_new_a;
                r_tail_b   <= w_new_b;
                r_tail_err <= w_new_err;
            end
        end
    end

`ifdef OPSEL_PARITY_EN
    logic w_new_par;
    logic r_head_par;
    logic r_tail_par;

    assign w_new_par = ^{w_new_a, w_new_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_par <= 1'b0;
            r_tail_par <= 1'b0;
        end else begin
            if (w_load_head_new) begin
                r_head_par <= w_new_par;
            end else if (w_shift) begin
                r_head_par <= r_tail_par;
            end
            if (w_load_tail) begin
                r_tail_par <= w_new_par;
            end
        end
    end

    assign par = out_valid ? r_head_par : 1'b0;
`else
    assign par = 1'b0;
`endif

    // Outputs are forced to zero whenever no entry is held.
    assign a       = out_valid ? r_head_a   : '0;
    assign b       = out_valid ? r_head_b   : '0;
    assign sel_err = out_valid ? r_head_err : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_operand_select_buf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_operand_select_buf
//  Purpose  : Self-checking bench for operand_select_buf (WIDTH=4, NSETS=3).
//             Expected entries are queued when a push handshake happens and
//             compared when the DUT pops them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_select_buf;

    localparam int WIDTH = 4;
    localparam int NSETS = 3;
    localparam int SEL_W = 2;
`ifdef OPSEL_PARITY_EN
    localparam bit c_PAR_EN = 1'b1;
`else
    localparam bit c_PAR_EN = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [SEL_W-1:0]       sel;
    logic                   swap;
    logic [NSETS*WIDTH-1:0] a_in;
    logic [NSETS*WIDTH-1:0] b_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   sel_err;
    logic                   par;

    operand_select_buf #(
        .WIDTH (WIDTH),
        .NSETS (NSETS),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .swap      (swap),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .sel_err   (sel_err),
        .par       (par)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             err;
        logic             par;
    } exp_t;

    typedef struct {
        logic [SEL_W-1:0]       sel;
        logic                   swap;
        logic [NSETS*WIDTH-1:0] a_in;
        logic [NSETS*WIDTH-1:0] b_in;
        logic [WIDTH-1:0]       ea;
        logic [WIDTH-1:0]       eb;
        logic                   eerr;
        logic                   epar;   // parity when the feature is built in
    } vec_t;

    vec_t vecs[7];
    exp_t sb_q[$];
    exp_t exp_cur;
    exp_t mon_e;
    int   n_applied = 0;
    int   n_miscompares = 0;

    // Reference model for random traffic
    function automatic exp_t model(input logic [SEL_W-1:0] s, input logic sw,
                                   input logic [NSETS*WIDTH-1:0] ai,
                                   input logic [NSETS*WIDTH-1:0] bi);
        exp_t e;
        int   idx;
        logic [WIDTH-1:0] pa, pb;
        idx   = (int'(s) < NSETS) ? int'(s) : 0;
        e.err = (int'(s) >= NSETS);
        pa    = ai[idx*WIDTH +: WIDTH];
        pb    = bi[idx*WIDTH +: WIDTH];
        e.a   = sw ? pb : pa;
        e.b   = sw ? pa : pb;
        e.par = c_PAR_EN ? ^{e.a, e.b} : 1'b0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [SEL_W-1:0] s, input logic sw,
                         input logic [NSETS*WIDTH-1:0] ai,
                         input logic [NSETS*WIDTH-1:0] bi, input exp_t e);
        in_valid = 1'b1;
        sel      = s;
        swap     = sw;
        a_in     = ai;
        b_in     = bi;
        exp_cur  = e;
    endtask

    task automatic wait_empty(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0 && !out_valid) done = 1'b1;
        end
        chk(name, {31'd0, done}, 32'd1);
        tick();
    endtask

    // Scoreboard monitor: pops are checked before this cycle's push is logged.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid) begin
                if (out_ready) begin
                    n_applied++;
                    if (sb_q.size() == 0) begin
                        n_miscompares++;
                        $display("FAIL pop_unexpected: got a=%0d b=%0d err=%0b par=%0b, none expected",
                                 a, b, sel_err, par);
                    end else begin
                        mon_e = sb_q.pop_front();
                        if ({a, b, sel_err, par} !== mon_e) begin
                            n_miscompares++;
                            $display("FAIL out_entry: got a=%0d b=%0d err=%0b par=%0b expected a=%0d b=%0d err=%0b par=%0b",
                                     a, b, sel_err, par, mon_e.a, mon_e.b, mon_e.err, mon_e.par);
                        end
                    end
                end
            end else begin
                n_applied++;
                if ({a, b, sel_err, par} !== '0) begin
                    n_miscompares++;
                    $display("FAIL idle_outputs: got a=%0d b=%0d err=%0b par=%0b expected all 0",
                             a, b, sel_err, par);
                end
            end
            if (in_valid && in_ready) sb_q.push_back(exp_cur);
        end
    end

    initial begin
        exp_t e;
        logic [NSETS*WIDTH-1:0] ra, rb;

        // a sets {3,7,9}, b sets {1,2,4} unless a vector overrides set 0
        vecs[0] = '{sel:2'd2, swap:1'b0, a_in:12'h973, b_in:12'h421, ea:4'd9,  eb:4'd4, eerr:1'b0, epar:1'b1};
        vecs[1] = '{sel:2'd2, swap:1'b1, a_in:12'h973, b_in:12'h421, ea:4'd4,  eb:4'd9, eerr:1'b0, epar:1'b1};
        vecs[2] = '{sel:2'd3, swap:1'b0, a_in:12'h976, b_in:12'h423, ea:4'd6,  eb:4'd3, eerr:1'b1, epar:1'b0};
        vecs[3] = '{sel:2'd3, swap:1'b1, a_in:12'h976, b_in:12'h423, ea:4'd3,  eb:4'd6, eerr:1'b1, epar:1'b0};
        vecs[4] = '{sel:2'd0, swap:1'b0, a_in:12'h97B, b_in:12'h421, ea:4'hB,  eb:4'd1, eerr:1'b0, epar:1'b0};
        vecs[5] = '{sel:2'd0, swap:1'b0, a_in:12'h978, b_in:12'h420, ea:4'd8,  eb:4'd0, eerr:1'b0, epar:1'b1};
        vecs[6] = '{sel:2'd1, swap:1'b0, a_in:12'h973, b_in:12'h421, ea:4'd7,  eb:4'd2, eerr:1'b0, epar:1'b0};

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        sel = '0; swap = 1'b0; a_in = 12'h973; b_in = 12'h421;
        exp_cur = '0;

        // Reset held with in_valid asserted
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        end
        tick();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_outputs", {22'd0, out_valid, a, b, sel_err, par}, 32'd0);
        tick();

        // Table vectors, downstream always ready
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            e.a = vecs[i].ea; e.b = vecs[i].eb; e.err = vecs[i].eerr;
            e.par = c_PAR_EN ? vecs[i].epar : 1'b0;
            drive(vecs[i].sel, vecs[i].swap, vecs[i].a_in, vecs[i].b_in, e);
            @(negedge clk);
            chk("tbl_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        wait_empty("tbl_drain");

        // Backpressure: only two of three accepted, no bypass
        out_ready = 1'b0;
        drive(2'd1, 1'b0, 12'h5A3, 12'hC61, model(2'd1, 1'b0, 12'h5A3, 12'hC61));
        @(negedge clk);
        chk("bp_no_bypass", {30'd0, in_ready, out_valid}, 32'd2);
        tick();
        drive(2'd2, 1'b1, 12'h5A3, 12'hC61, model(2'd2, 1'b1, 12'h5A3, 12'hC61));
        @(negedge clk);
        chk("bp_second", {30'd0, in_ready, out_valid}, 32'd3);
        tick();
        drive(2'd0, 1'b0, 12'h5A3, 12'hC61, model(2'd0, 1'b0, 12'h5A3, 12'hC61));
        @(negedge clk);
        chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        drive(2'd3, 1'b1, 12'hFFF, 12'hEEE, model(2'd3, 1'b1, 12'hFFF, 12'hEEE));
        @(negedge clk);
        chk("bp_full_hold", {31'd0, in_ready}, 32'd0);
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'd0, out_valid}, 32'd1);
        tick();
        @(negedge clk);
        chk("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
        tick();
        wait_empty("bp_drain");

        // Streaming at full rate
        for (int i = 0; i < 16; i++) begin
            ra = 12'($urandom);
            rb = 12'($urandom);
            drive(SEL_W'(i % NSETS), i[0], ra, rb, model(SEL_W'(i % NSETS), i[0], ra, rb));
            @(negedge clk);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        wait_empty("stream_drain");

        // Reset mid-burst discards buffered entries
        out_ready = 1'b0;
        drive(2'd1, 1'b0, 12'h123, 12'h456, model(2'd1, 1'b0, 12'h123, 12'h456));
        tick();
        drive(2'd2, 1'b0, 12'h789, 12'hABC, model(2'd2, 1'b0, 12'h789, 12'hABC));
        tick();
        in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_state", {30'd0, in_ready, out_valid}, 32'd2);
        tick();
        for (int i = 0; i < 3; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire
